// File: rtl/avg_pool2x2_engine.sv
// 2x2 average-pooling engine: 28x28 signed frame in, 14x14 means out.
// Define AVG_POOL_ROUND_EN for round-half-up instead of floor.
`timescale 1ns/1ps
module avg_pool2x2_engine #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [9:0]       pix_addr,
  input  logic [PIX_W-1:0] pix_data,
  output logic             out_valid,
  output logic [7:0]       out_addr,
  output logic [PIX_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int OW   = IMG_W / 2;
  localparam int OH   = IMG_H / 2;
  localparam int NWIN = OW * OH;
  localparam int AW   = PIX_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]          phase_q;
  logic [3:0]          r_q, c_q;
  logic [7:0]          win_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] pix_sx;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] pre;
  logic [9:0]          base;
  logic [9:0]          next_base;
  logic [9:0]          rd_addr;
  logic                last_col;
  logic                last_win;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (phase_q == 3'd4 && last_win) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    pix_sx    = {{2{pix_data[PIX_W-1]}}, pix_data};
    sum       = acc_q + pix_sx;
`ifdef AVG_POOL_ROUND_EN
    pre       = sum + AW'(2);
`else
    pre       = sum;
`endif
    last_col  = (c_q == 4'(OW - 1));
    last_win  = (win_q == 8'(NWIN - 1));
    base      = 10'(r_q) * 10'(2 * IMG_W) + 10'({c_q, 1'b0});
    next_base = last_col ? (10'(r_q) + 10'd1) * 10'(2 * IMG_W)
                         : base + 10'd2;
    // address for the phase that follows the current one
    unique case (phase_q)
      3'd0:    rd_addr = base + 10'd1;
      3'd1:    rd_addr = base + 10'(IMG_W);
      3'd2:    rd_addr = base + 10'(IMG_W + 1);
      default: rd_addr = next_base;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      r_q       <= '0;
      c_q       <= '0;
      win_q     <= '0;
      acc_q     <= '0;
      pix_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            phase_q  <= '0;
            r_q      <= '0;
            c_q      <= '0;
            win_q    <= '0;
            pix_addr <= '0;
            done     <= 1'b0;
          end
        end
        RUN: begin
          unique case (phase_q)
            3'd0: ;
            3'd1: acc_q <= pix_sx;
            3'd2,
            3'd3: acc_q <= sum;
            default: begin
              out_valid <= 1'b1;
              out_addr  <= win_q;
              out_data  <= PIX_W'(pre >>> 2);
            end
          endcase
          if (phase_q == 3'd4) begin
            phase_q <= '0;
            if (!last_win) begin
              win_q    <= win_q + 8'd1;
              pix_addr <= rd_addr;
              c_q      <= last_col ? 4'd0 : c_q + 4'd1;
              r_q      <= last_col ? r_q + 4'd1 : r_q;
            end
          end else begin
            phase_q <= phase_q + 3'd1;
            if (phase_q != 3'd3) pix_addr <= rd_addr;
          end
        end
        FIN:     done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_pool2x2_engine.sv
// Bench for avg_pool2x2_engine: vector table plus full-frame scoreboard.
// Expected means come from integer arithmetic over a pixel-memory model.
`timescale 1ns/1ps
module tb_avg_pool2x2_engine;

  localparam int W  = 28;
  localparam int NW = 196;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] pix_addr;
  logic [7:0] pix_data;
  logic       out_valid;
  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  avg_pool2x2_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pix_addr (pix_addr),
    .pix_data (pix_data),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  logic [7:0] mem [784];

  always @(posedge clk)
    pix_data <= (pix_addr < 10'd784) ? mem[pix_addr] : 8'h00;

  int checks = 0;
  int errors = 0;
  int exp_v [NW];

  typedef struct {
    int p0, p1, p2, p3;
    int e_floor;
    int e_round;
  } vec_t;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int floor4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  function automatic int model_avg(input int s);
`ifdef AVG_POOL_ROUND_EN
    return floor4(s + 2);
`else
    return floor4(s);
`endif
  endfunction

  function automatic int px(input int a);
    return int'($signed(mem[a]));
  endfunction

  function automatic void build_exp();
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) begin
        int b;
        b = 2 * r * W + 2 * c;
        exp_v[r * 14 + c] =
          model_avg(px(b) + px(b + 1) + px(b + W) + px(b + W + 1));
      end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 784; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_frame(input int pulse_win, input int reset_win);
    int  j;
    int  abort_k;
    bit  aborted;
    build_exp();
    j = 0;
    aborted = 1'b0;
    abort_k = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("done_after_start", int'(done), 0);
    for (int k = 1; k <= 990; k++) begin
      if (out_valid) begin
        if (aborted) begin
          check("strobe_after_reset", int'(out_valid), 0);
        end else if (j < NW) begin
          check("strobe_cycle", k, 6 + 5 * j);
          check("out_addr", int'(out_addr), j);
          check("out_data", int'($signed(out_data)), exp_v[j]);
          j++;
        end else begin
          check("extra_strobe", int'(out_valid), 0);
        end
      end
      if (aborted && k == abort_k + 1) begin
        check("busy_in_reset", int'(busy), 0);
        check("done_in_reset", int'(done), 0);
      end
      if (aborted && k == abort_k + 2) reset = 1'b0;
      if (aborted && k == abort_k + 20) break;
      if (!aborted && k == 982) begin
        check("done_at_982", int'(done), 1);
        check("busy_at_982", int'(busy), 0);
        check("strobe_count", j, NW);
        break;
      end
      if (pulse_win >= 0 && k == 6 + 5 * pulse_win) start = 1'b1;
      if (pulse_win >= 0 && k == 7 + 5 * pulse_win) start = 1'b0;
      if (!aborted && reset_win >= 0 && k == 6 + 5 * reset_win) begin
        reset   = 1'b1;
        aborted = 1'b1;
        abort_k = k;
      end
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  vec_t vecs [6];
  int   nstrobe;

  initial begin
    vecs[0] = '{10, 11, 12, 13, 11, 12};
    vecs[1] = '{-1, -1, -1, -2, -2, -1};
    vecs[2] = '{127, 127, 127, 127, 127, 127};
    vecs[3] = '{-128, -128, -128, -128, -128, -128};
    vecs[4] = '{-1, 0, 0, 0, -1, 0};
    vecs[5] = '{1, 1, 1, 0, 0, 1};

    for (int i = 0; i < 784; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    do_reset();

    check("rst_pix_addr", int'(pix_addr), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    nstrobe = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) nstrobe++;
    end
    check("idle_strobes", nstrobe, 0);

    for (int v = 0; v < 6; v++) begin
      int want;
`ifdef AVG_POOL_ROUND_EN
      want = vecs[v].e_round;
`else
      want = vecs[v].e_floor;
`endif
      do_reset();
      fill_random();
      mem[0]     = 8'(vecs[v].p0);
      mem[1]     = 8'(vecs[v].p1);
      mem[W]     = 8'(vecs[v].p2);
      mem[W + 1] = 8'(vecs[v].p3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("vec_early_strobe", int'(out_valid), 0);
      @(negedge clk);
      check("vec_valid", int'(out_valid), 1);
      check("vec_addr", int'(out_addr), 0);
      check("vec_data", int'($signed(out_data)), want);
    end

    do_reset();
    for (int i = 0; i < 784; i++) mem[i] = 8'(i % 256);
    run_frame(-1, -1);

    fill_random();
    run_frame(50, -1);

    fill_random();
    run_frame(-1, 100);

    fill_random();
    run_frame(-1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_pool2x2_engine.md
Name: avg_pool2x2_engine

Overview:
- Frame-level 2x2 average-pooling engine.
- Reads a 28x28 signed 8-bit image from a synchronous-read pixel memory, one pixel per cycle.
- Averages each non-overlapping 2x2 window and writes the 14x14 result (196 values) through a write-style output port.
- Sits between the image buffer and the first dense layer; its done flag is the dense layer's start condition.

Parameters:
- IMG_W, 28, image width in pixels; even.
- IMG_H, 28, image height in pixels; even.
- PIX_W, 8, pixel and result width, signed two's complement.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to pool a full frame; ignored while busy.
- pix_addr  out  10  pixel memory read address, row-major (row*IMG_W+col).
- pix_data  in  PIX_W  signed pixel; valid one cycle after pix_addr is presented.
- out_valid  out  1  one-cycle strobe; out_data/out_addr valid.
- out_addr  out  8  pooled index, r*(IMG_W/2)+c, 0..195.
- out_data  out  PIX_W  signed pooled average.
- busy  out  1  high while a frame is in progress.
- done  out  1  level; high after the last window, until next accepted start or reset.

Behaviour:
- Reset: state IDLE; pix_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0. Accumulator cleared.
- States: IDLE -> RUN (on start while not busy) -> FIN -> IDLE.
- On accepted start: busy=1 and done=0 on the next cycle; window (r,c)=(0,0).
- Window order is row-major over r,c in 0..13.
- Window base address: b = 2r*IMG_W + 2c.
- Per window, addresses b, b+1, b+IMG_W, b+IMG_W+1 are issued on four consecutive cycles T..T+3.
- Data for those addresses is sampled at T+1..T+4 and summed in a sign-extended (PIX_W+2)-bit accumulator.
- At T+5: out_valid=1, out_data=sum>>>2 (arithmetic shift, floor), out_addr=window index. The next window's first address is also issued at T+5.
- Throughput: exactly 5 cycles per window, 980 cycles per frame.
- First out_valid is 6 cycles after start is sampled.
- After window 195's out_valid: FIN for one cycle, then busy=0 and done=1 together; return to IDLE.
- pix_addr holds its last value when not reading.
- Result always fits PIX_W: mean of four signed PIX_W values lies in range, no saturation needed.
- start while busy: ignored, no restart.
- start in the same cycle done is high: accepted; done drops the next cycle.
- reset mid-frame: immediate return to reset state; no further out_valid; partial sums discarded.
- reset and start in the same cycle: reset wins.

Optional Feature:
- Macro: AVG_POOL_ROUND_EN.
- Defined: out_data=(sum+2)>>>2 (round half toward +inf).
- Undefined: out_data=sum>>>2 (floor).
- Timing, ports and all other behaviour identical in both builds.

Test Plan:
- Reset then idle, no start -> all outputs 0; no out_valid for 100 cycles.
- Window pixels 10,11,12,13 at addr 0,1,28,29, start -> out_valid at cycle 6, out_addr=0, out_data=11 (12 with AVG_POOL_ROUND_EN).
- Window pixels -1,-1,-1,-2 -> out_data=-2 floor (-1 rounded); all-127 window -> 127; all -128 -> -128.
- Full frame, pixel = (addr mod 256) as signed -> 196 strobes at 5-cycle spacing, out_addr 0..195 in order, each equal to the model average; done=1 and busy=0 at cycle 982.
- Pulse start at window 50 -> ignored, sequence continues unaffected.
- Assert reset at window 100, then restart -> no strobes after reset; new frame begins at out_addr=0 with correct values.
